// File: rtl/scr1_ahb_ram_slv_pkg.sv
// AHB-Lite constants and byte-lane helper
// shared by the AHB RAM slave and its bench
package scr1_ahb_ram_slv_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  function automatic logic [3:0] be_of(
    input logic [2:0] size,
    input logic [1:0] off
  );
    be_of = 4'b0000;
    unique case (1'b1)
      size == HSIZE_BYTE: be_of = 4'b0001 << off;
      size == HSIZE_HALF: be_of = off[1] ? 4'b1100
                                         : 4'b0011;
      default:            be_of = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/scr1_ahb_ram_slv_if.sv
// AHB-Lite slave-side bus bundle
// master drives requests, slave returns ready/resp/data
interface scr1_ahb_ram_slv_if;

  logic        hsel;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic        hresp;

  modport slave (
    input  hsel, htrans, hsize, haddr,
    input  hwrite, hwdata, hready,
    output hreadyout, hrdata, hresp
  );

  modport master (
    output hsel, htrans, hsize, haddr,
    output hwrite, hwdata, hready,
    input  hreadyout, hrdata, hresp
  );

endinterface

// File: rtl/scr1_ahb_ram_slv.sv
// AHB-Lite slave bridging to an external 1-cycle
// synchronous SRAM, with optional wait states
module scr1_ahb_ram_slv
  import scr1_ahb_ram_slv_pkg::*;
#(
  parameter int unsigned SCR1_RAM_AW   = 12,
  parameter logic [31:0] SCR1_RAM_BASE = 32'h0,
  parameter int unsigned SCR1_RAM_WS   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  scr1_ahb_ram_slv_if.slave      ahb,
  output logic                   ram_ce,
  output logic                   ram_we,
  output logic [3:0]             ram_be,
  output logic [SCR1_RAM_AW-1:0] ram_addr,
  output logic [31:0]            ram_wdata,
  input  logic [31:0]            ram_rdata
);

  localparam int unsigned AW = SCR1_RAM_AW;
  localparam logic [1:0] WS = 2'(SCR1_RAM_WS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [1:0]    cnt;
  logic [1:0]    cnt_nx;
  logic          a_write;
  logic [3:0]    a_be;
  logic [AW-1:0] a_addr;
  logic [31:0]   rdata_q;
  logic          accept;
  logic          err;
  logic          take;

  assign accept = ahb.hsel & ahb.hready &
                  ((ahb.htrans == HTRANS_NONSEQ) |
                   (ahb.htrans == HTRANS_SEQ));

  always_comb begin
    err = 1'b0;
    if (ahb.hsize > HSIZE_WORD)
      err = 1'b1;
    if (ahb.hsize == HSIZE_HALF && ahb.haddr[0])
      err = 1'b1;
    if (ahb.hsize == HSIZE_WORD &&
        ahb.haddr[1:0] != 2'b00)
      err = 1'b1;
    if (ahb.haddr[31:AW+2] !=
        SCR1_RAM_BASE[31:AW+2])
      err = 1'b1;
  end

  // a new address phase is taken only while the
  // current data phase is finishing (or idle)
  assign take = accept & ahb.hreadyout;

  always_comb begin
    ahb.hreadyout = 1'b1;
    ahb.hresp     = HRESP_OKAY;
    case (state)
      ST_WAIT: ahb.hreadyout = (cnt == 2'd0) & a_write;
      ST_ERR1: begin
        ahb.hreadyout = 1'b0;
        ahb.hresp     = HRESP_ERROR;
      end
      ST_ERR2: ahb.hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // the access cycle is the last ST_WAIT cycle
  assign ram_ce    = (state == ST_WAIT) &
                     (cnt == 2'd0);
  assign ram_we    = ram_ce & a_write;
  assign ram_be    = a_be;
  assign ram_addr  = a_addr;
  assign ram_wdata = ahb.hwdata;

  assign ahb.hrdata = (state == ST_RD) ? ram_rdata
                                       : rdata_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_WAIT: begin
        if (cnt != 2'd0)
          cnt_nx = cnt - 2'd1;
        else if (!a_write)
          state_nx = ST_RD;
      end
      ST_ERR1: state_nx = ST_ERR2;
      default: ;
    endcase
    if (ahb.hreadyout) begin
      state_nx = ST_IDLE;
      if (take) begin
        state_nx = err ? ST_ERR1 : ST_WAIT;
        cnt_nx   = err ? 2'd0 : WS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_write <= 1'b0;
      a_be    <= 4'b0000;
      a_addr  <= '0;
    end else if (take && !err) begin
      a_write <= ahb.hwrite;
      a_be    <= be_of(ahb.hsize, ahb.haddr[1:0]);
      a_addr  <= ahb.haddr[AW+1:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata_q <= 32'h0;
    else if (state == ST_RD)
      rdata_q <= ram_rdata;
  end

endmodule
